// File: rtl/tx_pkt_sched_if.sv
// Control, FIFO and DAC signals of the transmit packet scheduler.
// The master modport is the surrounding system; the slave modport is tx_pkt_sched.
interface tx_pkt_sched_if;
    logic       start;
    logic       abort;
    logic [7:0] fifo_length;
    logic       fifo_rd_en;
    logic [7:0] fifo_data;
    logic       dac_wr_en;
    logic [7:0] dac_data;
    logic       dac_busy;
    logic       busy;
    logic       done;
    logic [7:0] status;

    modport master (
        output start, abort, fifo_length, fifo_data, dac_busy,
        input  fifo_rd_en, dac_wr_en, dac_data, busy, done, status
    );

    modport slave (
        input  start, abort, fifo_length, fifo_data, dac_busy,
        output fifo_rd_en, dac_wr_en, dac_data, busy, done, status
    );
endinterface

// File: rtl/tx_pkt_sched.sv
// Transmit packet scheduler: pops packet bytes from the FIFO and hands them to the DAC path.
// Optional feature macro TX_PREAMBLE_EN prepends PREAMBLE_LEN 0xAA bytes and a 0xD5 SFD.
module tx_pkt_sched #(
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
`ifdef TX_PREAMBLE_EN
    ,
    parameter int unsigned PREAMBLE_LEN   = 4
`endif
) (
    input  logic          i_clk,
    input  logic          i_reset,
    tx_pkt_sched_if.slave io_bus
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_CAPTURE  = 3'd2;
    localparam logic [2:0] ST_WAIT_DAC = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;
`ifdef TX_PREAMBLE_EN
    localparam logic [2:0] ST_PREAMBLE = 3'd6;
    localparam int unsigned PW = (PREAMBLE_LEN > 0) ? $clog2(PREAMBLE_LEN + 1) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_LEN);
`endif

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [2:0]    r_state;
    logic [7:0]    r_remaining;
    logic [7:0]    r_dac_data;
    logic [3:0]    r_status;
    logic [TW-1:0] r_tmo;
    logic [GW-1:0] r_gap;
    logic          r_zl_done;
`ifdef TX_PREAMBLE_EN
    logic [PW-1:0] r_pre_cnt;
    logic          r_in_pre;
`endif

    logic       w_wr;
    logic       w_abort_hit;
    logic       w_timeout;
    logic       w_pre_more;
    logic [2:0] w_first;
    logic [2:0] w_post;
    logic [2:0] w_state_nxt;

    // Any pending write is dropped when abort lands in WAIT_DAC.
    assign w_wr        = (r_state == ST_WAIT_DAC) && !io_bus.dac_busy && !io_bus.abort;
    assign w_abort_hit = io_bus.abort && (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_timeout   = (r_state == ST_WAIT_DAC) && io_bus.dac_busy && (r_tmo == TMO_LAST);

`ifdef TX_PREAMBLE_EN
    // In WAIT_DAC the SFD write itself ends the preamble phase.
    assign w_pre_more = r_in_pre && !((r_state == ST_WAIT_DAC) && (r_pre_cnt == PRE_LAST));
    assign w_first    = ST_PREAMBLE;
    assign w_post     = w_pre_more ? ST_PREAMBLE :
                        ((r_remaining != 8'd0) ? ST_FETCH : ST_DONE);
`else
    assign w_pre_more = 1'b0;
    assign w_first    = ST_FETCH;
    assign w_post     = (w_pre_more || (r_remaining != 8'd0)) ? ST_FETCH : ST_DONE;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.start && (io_bus.fifo_length != 8'd0)) begin
                    w_state_nxt = w_first;
                end
            end
            ST_FETCH:   w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: w_state_nxt = ST_WAIT_DAC;
`ifdef TX_PREAMBLE_EN
            ST_PREAMBLE: w_state_nxt = ST_WAIT_DAC;
`endif
            ST_WAIT_DAC: begin
                if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end else if (!io_bus.dac_busy) begin
                    w_state_nxt = (GAP_CYCLES == 0) ? w_post : ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_state_nxt = w_post;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_abort_hit) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= 8'd0;
            r_dac_data  <= 8'd0;
            r_status    <= 4'd0;
            r_tmo       <= '0;
            r_gap       <= '0;
            r_zl_done   <= 1'b0;
`ifdef TX_PREAMBLE_EN
            r_pre_cnt   <= '0;
            r_in_pre    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_zl_done <= 1'b0;
            if ((r_state == ST_IDLE) && io_bus.start) begin
                r_remaining <= io_bus.fifo_length;
                if (io_bus.fifo_length == 8'd0) begin
                    r_status  <= 4'b0101;
                    r_zl_done <= 1'b1;
                end else begin
                    r_status <= 4'b0000;
`ifdef TX_PREAMBLE_EN
                    r_in_pre  <= 1'b1;
                    r_pre_cnt <= '0;
`endif
                end
            end
            // Counting at the pop is equivalent to counting at the write for the loop decision.
            if (r_state == ST_FETCH) begin
                r_remaining <= r_remaining - 8'd1;
            end
            if (r_state == ST_CAPTURE) begin
                r_dac_data <= io_bus.fifo_data;
            end
`ifdef TX_PREAMBLE_EN
            if (r_state == ST_PREAMBLE) begin
                r_dac_data <= (r_pre_cnt == PRE_LAST) ? 8'hD5 : 8'hAA;
            end
            if (w_wr && r_in_pre) begin
                r_pre_cnt <= r_pre_cnt + 1'b1;
                if (r_pre_cnt == PRE_LAST) begin
                    r_in_pre <= 1'b0;
                end
            end
`endif
            r_tmo <= ((r_state == ST_WAIT_DAC) && (w_state_nxt == ST_WAIT_DAC)) ?
                     r_tmo + 1'b1 : '0;
            r_gap <= ((r_state == ST_GAP) && (w_state_nxt == ST_GAP)) ? r_gap + 1'b1 : '0;
            if (w_abort_hit) begin
                r_status[3] <= 1'b1;
            end else if (w_timeout) begin
                r_status[1] <= 1'b1;
            end
            if (r_state == ST_DONE) begin
                r_status[0] <= 1'b1;
            end
        end
    end

    assign io_bus.fifo_rd_en = (r_state == ST_FETCH);
    assign io_bus.dac_wr_en  = w_wr;
    assign io_bus.dac_data   = r_dac_data;
    assign io_bus.busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign io_bus.done       = (r_state == ST_DONE) || r_zl_done;
    assign io_bus.status     = {4'b0000, r_status};

endmodule
